// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared types and constants for the iterative DES S-box substitution stage.
//   sbox_in_t  : one 6-bit group presented to an S-box
//   sbox_out_t : one 4-bit S-box result nibble
//   state_t    : sequencer FSM states
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int SBOX_COUNT = 8;

  typedef logic [5:0] sbox_in_t;
  typedef logic [3:0] sbox_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/des_sbox_rom.sv
// -----------------------------------------------------------------------------
// des_sbox_rom
//   Combinational lookup into the DES S-boxes S1..S8 (FIPS 46-3).
//   Ports:
//     sel [2:0] : S-box index (0 selects S1 ... 7 selects S8)
//     x   [5:0] : 6-bit group; row = {x[5],x[0]}, column = x[4:1]
//     y   [3:0] : substituted nibble
//   Each table is packed as 64 nibbles, entry (row*16+col) at the MS end first,
//   so one row of the printed table reads left to right as 16 hex digits.
// -----------------------------------------------------------------------------
module des_sbox_rom
  import des_pkg::*;
(
  input  logic [2:0] sel,
  input  sbox_in_t   x,
  output sbox_out_t  y
);

  logic [255:0] tab;
  logic [5:0]   idx;
  logic [7:0]   pos;

  always_comb begin
    case (sel)
      3'd0: tab = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1: tab = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2: tab = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3: tab = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4: tab = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5: tab = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAB1E7608D;
      3'd6: tab = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: tab = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
    idx = {x[5], x[0], x[4:1]};
    // Entry i occupies bits [255-4i -: 4], i.e. [252-4i +: 4].
    pos = 8'd252 - {idx, 2'b00};
    y   = tab[pos +: 4];
  end

endmodule

// File: rtl/des_sbox_sequencer.sv
// -----------------------------------------------------------------------------
// des_sbox_sequencer
//   Iterative DES f-function substitution stage. A 48-bit post-XOR word is
//   accepted, its eight 6-bit groups are pushed through LOOKUPS shared S-box
//   lanes (8/LOOKUPS RUN cycles), and the 32-bit result is presented with a
//   valid/ready handshake.
//   Parameters:
//     LOOKUPS   : parallel S-box lookups per cycle (1, 2, 4 or 8)
//   Ports:
//     clk, rst  : rising-edge clock, asynchronous active-high reset
//     in_data   : group g = in_data[47-6g -: 6] feeds S-box g+1
//     in_valid/in_ready   : input handshake
//     out_data  : nibble g = out_data[31-4g -: 4]; retained after hand-off
//     out_valid/out_ready : output handshake
//     abort     : (only with DES_SBOX_ABORT_EN) drop the block in RUN/DONE
//     busy      : high while in RUN
//   Build option: define DES_SBOX_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module des_sbox_sequencer
  import des_pkg::*;
#(
  parameter int LOOKUPS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DES_SBOX_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy
);

  if (LOOKUPS != 1 && LOOKUPS != 2 && LOOKUPS != 4 && LOOKUPS != 8) begin : g_bad_lookups
    $error("des_sbox_sequencer: LOOKUPS must be 1, 2, 4 or 8");
  end

  localparam int STEPS = SBOX_COUNT / LOOKUPS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t           state_q, state_d;
  logic [47:0]      in_q, in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      out_q, out_d;

  sbox_in_t  grp      [SBOX_COUNT];
  logic [2:0] lane_sel [LOOKUPS];
  sbox_out_t lane_y   [LOOKUPS];

  for (genvar g = 0; g < SBOX_COUNT; g++) begin : g_split
    assign grp[g] = in_q[47-6*g -: 6];
  end

  // Lane l serves group cnt*LOOKUPS + l in the current RUN step.
  for (genvar l = 0; l < LOOKUPS; l++) begin : g_lane
    assign lane_sel[l] = 3'(int'(cnt_q) * LOOKUPS + l);
    des_sbox_rom u_rom (
      .sel (lane_sel[l]),
      .x   (grp[lane_sel[l]]),
      .y   (lane_y[l])
    );
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_d    = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        for (int g = 0; g < SBOX_COUNT; g++) begin
          for (int l = 0; l < LOOKUPS; l++) begin
            if (lane_sel[l] == 3'(g)) out_d[31-4*g -: 4] = lane_y[l];
          end
        end
        // Counter parks at LAST and is only reloaded by the next accept.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          // Back-to-back: a waiting block starts in the same edge as hand-off.
          if (in_valid) begin
            in_d    = in_data;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DES_SBOX_ABORT_EN
    // Abort outranks the DONE handshake; nothing is accepted on that edge.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      in_d     = in_q;
      out_d    = out_q;
      in_ready = 1'b0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule
